// File: rtl/instr_feeder_if.sv
// Purpose: bundles the loader/control inputs, the core handshake (DIN/Run/Done) and status of instr_feeder.
// Latency: none, wiring only.
// Backpressure: none; the core paces the feeder through Done.
// Ports: master = feeder side (drives DIN/Run/status); slave = environment side (drives Start/Load_*/Done).
interface instr_feeder_if #(
  parameter int ADDR_W = 4
);
  logic              Start;
  logic              Load_En;
  logic [ADDR_W-1:0] Load_Addr;
  logic [8:0]        Load_Data;
  logic              Done;
  logic [8:0]        DIN;
  logic              Run;
  logic [ADDR_W-1:0] PC;
  logic              Busy;
  logic              Halted;
  logic              Error;
  logic [7:0]        Retired;

  modport master (
    input  Start, Load_En, Load_Addr, Load_Data, Done,
    output DIN, Run, PC, Busy, Halted, Error, Retired
  );

  modport slave (
    output Start, Load_En, Load_Addr, Load_Data, Done,
    input  DIN, Run, PC, Busy, Halted, Error, Retired
  );
endinterface

// File: rtl/instr_feeder.sv
// Purpose: autonomous fetch stage feeding the 9-bit core from a loadable program memory until HALT or Done timeout.
// Latency: Start at edge N gives Run in cycle N+1; next issue follows the cycle in which Done is seen.
// Backpressure: core stalls the sequencer by withholding Done; TIMEOUT WAIT cycles without Done force an error halt.
// Ports: Clock, Resetn (async active-low); bus.master carries Start/Load_*/Done in and DIN/Run/PC/Busy/Halted/Error/Retired out.
module instr_feeder #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            Clock,
  input  logic            Resetn,
  instr_feeder_if.master  bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_IMM, S_WAIT, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        retired_q, retired_d;
  logic              error_q, error_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run;
  logic [8:0]        din;

  logic [8:0]        mem [DEPTH];
  logic [8:0]        word;
  logic [2:0]        opcode;
  logic              ctrl_open;

  assign word      = mem[pc_q];
  assign opcode    = word[8:6];
  assign ctrl_open = (state_q == S_IDLE) || (state_q == S_HALT);

  // Program memory is deliberately outside the reset domain so a reset keeps the loaded program.
  always_ff @(posedge Clock) begin
    if (ctrl_open && bus.Load_En) begin
      mem[bus.Load_Addr] <= bus.Load_Data;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      retired_q <= '0;
      error_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      error_q   <= error_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    error_d   = error_q;
    cnt_d     = cnt_q;
    run       = 1'b0;
    din       = '0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.Start) begin
          pc_d      = '0;
          retired_d = '0;
          error_d   = 1'b0;
          cnt_d     = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // HALT words are consumed here and never reach the core.
        if (opcode == 3'd7) begin
          state_d = S_HALT;
        end else begin
          run     = 1'b1;
          din     = word;
          pc_d    = pc_q + 1'b1;
          state_d = (opcode == 3'd1) ? S_IMM : S_WAIT;
        end
      end
      S_IMM: begin
        // Immediate word follows the mvi opcode; the core may finish in this same cycle.
        din  = word;
        pc_d = pc_q + 1'b1;
        if (bus.Done) begin
          retired_d = retired_q + 8'd1;
          state_d   = S_ISSUE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.Done) begin
          retired_d = retired_q + 8'd1;
          cnt_d     = '0;
          state_d   = S_ISSUE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th WAIT cycle without Done.
          error_d = 1'b1;
          cnt_d   = '0;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.Run     = run;
  assign bus.DIN     = din;
  assign bus.PC      = pc_q;
  assign bus.Busy    = (state_q == S_ISSUE) || (state_q == S_IMM) || (state_q == S_WAIT);
  assign bus.Halted  = (state_q == S_HALT);
  assign bus.Error   = error_q;
  assign bus.Retired = retired_q;
endmodule

// File: doc/instr_feeder.md
# instr_feeder

Program sequencer that sits directly upstream of the 9-bit processor core and drives its `DIN`/`Run` inputs. It holds a small loadable program memory and issues each instruction word (plus the immediate word for `mvi`) with the timing the core expects. It advances on the core's `Done` and stops on a HALT word or a Done timeout. This block replaces hand-driven `DIN`/`Run` stimulus with an autonomous fetch stage.

## Interface
- `DEPTH`, 16: program memory words; power of two.
- `ADDR_W`, 4: log2(`DEPTH`).
- `TIMEOUT`, 15: max cycles spent in WAIT without `Done` before error halt.
- `Clock` input 1: single clock; all state updates on rising edge.
- `Resetn` input 1: asynchronous, active-low reset.
- `Start` input 1: begin execution at address 0; honoured only in IDLE or HALT.
- `Load_En` input 1: program-memory write strobe; honoured only in IDLE or HALT.
- `Load_Addr` input `ADDR_W`: write address.
- `Load_Data` input 9: write data.
- `Done` input 1: core's instruction-complete flag.
- `DIN` output 9: instruction/immediate word to core.
- `Run` output 1: one-cycle issue strobe to core.
- `PC` output `ADDR_W`: current fetch address.
- `Busy` output 1: high in ISSUE, IMM, WAIT.
- `Halted` output 1: high in HALT.
- `Error` output 1: set on timeout; cleared by reset or accepted `Start`.
- `Retired` output 8: count of completed instructions, modulo 256.

## Operation
- Word format: `[8:6]` opcode, `[5:3]` RX, `[2:0]` RY. Opcodes 0 mv, 1 mvi, 2 add, 3 sub are forwarded to the core. Opcode 7 is HALT and is consumed locally, never issued. Opcodes 4–6 are forwarded unchanged.
- Memory: `DEPTH` × 9, synchronous write, combinational read at `mem[PC]`. Contents are not affected by reset.
- FSM states: IDLE, ISSUE, IMM, WAIT, HALT.
- IDLE: `Run`=0, `DIN`=0.
  - `Load_En` writes `Load_Data` to `mem[Load_Addr]`.
  - `Start` sets `PC`←0, `Retired`←0, `Error`←0, then ISSUE.
  - If `Start` and `Load_En` are high in the same cycle, the write happens and the start is taken. The first fetch sees the written data.
- ISSUE, word = `mem[PC]`:
  - Opcode 7: `Run`=0, `DIN`=0, `PC` held, then HALT.
  - Otherwise: `Run`=1, `DIN`=word, `PC`←`PC`+1 (wraps `DEPTH`-1→0).
  - Next state is IMM if opcode 1, else WAIT.
- IMM: `Run`=0, `DIN`=`mem[PC]`, `PC`←`PC`+1 (wraps).
  - `Done`=1: `Retired`++, then ISSUE.
  - Otherwise: WAIT.
- WAIT: `Run`=0, `DIN`=0, timeout counter increments.
  - `Done`=1: `Retired`++, counter cleared, then ISSUE.
  - Counter reaches `TIMEOUT` without `Done`: `Error`←1, then HALT.
- HALT: `Run`=0, `DIN`=0.
  - `Load_En` is honoured.
  - `Start` behaves as in IDLE.
- `Start` and `Load_En` are ignored while `Busy`.
- `Done` is ignored in IDLE, ISSUE, HALT.

## Timing
- Reset values: state IDLE, `DIN`=0, `Run`=0, `PC`=0, `Busy`=0, `Halted`=0, `Error`=0, `Retired`=0, timeout counter 0.
- Reset asserted mid-program: all of the above apply immediately. `Run` drops asynchronously.
- `Run` and `DIN` are combinational from state and `mem[PC]`. `Run` is never high for two consecutive cycles.
- `Start` sampled at edge N → ISSUE in cycle N+1 with `Run`=1.
- Back-to-back issue rules:
  - mvi: 2 cycles (ISSUE, IMM with `Done`).
  - mv: 2 cycles (ISSUE, WAIT with `Done`).
  - add/sub: 4 cycles (ISSUE, WAIT×3, `Done` in 3rd).
  - Next ISSUE is in the cycle after `Done`.
- HALT word: one ISSUE cycle with `Run`=0, then `Halted`=1 the following cycle.
- Timeout: `Error` and `Halted` rise in the cycle after the WAIT cycle in which the counter hits `TIMEOUT`.

## Test plan
- Reset, load mem[0..5] = 9'o100, 9'o005, 9'o010, 9'o201, 9'o300, 9'o700, pulse `Start`, with a core model giving `Done` per Timing:
  - `Run` pulses with `DIN` = 100, 010, 201, 300 in cycles 1, 3, 5, 9.
  - `DIN`=005 in cycle 2.
  - `Halted`=1 at cycle 14, `PC`=5, `Retired`=4, `Error`=0.
- Core never asserts `Done` after 9'o201 → `Error`=1, `Halted`=1 exactly `TIMEOUT`+1 cycles after the issue cycle; `Retired` unchanged.
- mvi at address 15 (immediate at 0), HALT at address 1:
  - `PC` wraps 15→0→1.
  - `DIN`=mem[0] in the IMM cycle.
  - HALT with `PC`=1.
- `Load_En` and `Start` pulsed while `Busy` → memory readback unchanged, `PC` sequence unaffected.
- Assert `Resetn`=0 in the WAIT cycle of an add → `Run`=0, `DIN`=0, `PC`=0, `Retired`=0 immediately. Program restarts cleanly after `Start`.
- From HALT with `Error`=1, pulse `Start` → `Error`=0, `Retired`=0, ISSUE at `PC`=0 next cycle.
